arrow_decoder: RTL

ARROW_DECODER -- requirements
Module: arrow_decoder

---
 rtl/arrow_pkg.sv | 37 +++
 rtl/arrow_frame_model.sv | 37 +++
 rtl/arrow_decoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/arrow_pkg.sv
// Shared types and normalized lamp tables for the arrow board decoder.
// Table entries are indexed by pattern code 0..F.
package arrow_pkg;

    typedef enum logic [1:0] {
        WAIT0   = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2,
        REPORT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] pattern;
        logic       flashing;
        logic       sequential;
        logic       ambiguous;
        logic       lamp_test;
        logic       blank;
        logic       error;
    } result_t;

    localparam logic [15:0] STEADY [0:15] = '{
        16'h20FD, 16'h905F, 16'h20FD, 16'h905F, 16'h20FD, 16'h905F, 16'h20FD, 16'h905F,
        16'hEAFF, 16'hF57F, 16'hEA95, 16'hF554, 16'hB0DD, 16'hA000, 16'h007F, 16'hB9D5
    };

    localparam logic [15:0] SEQ0 [0:15] = '{
        16'h0060, 16'h0003, 16'h0060, 16'h0003, 16'h0070, 16'h0007, 16'h8870, 16'h2107,
        16'h8870, 16'h2107, 16'h8810, 16'h2104, 16'h0000, 16'h2000, 16'h0000, 16'h2185
    };

    localparam logic [15:0] SEQ1 [0:15] = '{
        16'h0078, 16'h000F, 16'h007C, 16'h001F, 16'h007C, 16'h001F, 16'h4274, 16'h4417,
        16'hCA7C, 16'h651F, 16'hCA14, 16'h6514, 16'h0000, 16'h8000, 16'h0000, 16'h9850
    };

endpackage

// File: rtl/arrow_frame_model.sv
// Expected normalized lamp frame for one candidate pattern/mode at one board phase.
module arrow_frame_model
    import arrow_pkg::*;
(
    input  logic [3:0]  pattern,
    input  logic [1:0]  phase,
    input  logic        flashing,
    input  logic        sequential,
    output logic [15:0] frame
);

    logic [15:0] seq_frame;

    always_comb begin
        seq_frame = phase[0] ? SEQ1[pattern] : SEQ0[pattern];
        frame     = STEADY[pattern];
        if (pattern < 4'hC) begin
            // Sequential boards only animate during the first half of the cycle.
            if (sequential && !phase[1]) begin
                frame = seq_frame;
            end else if (flashing && phase[0]) begin
                frame = 16'h0000;
            end
        end else if (!pattern[0]) begin
            if ((sequential || flashing) && phase[0]) begin
                frame = 16'h0000;
            end
        end else begin
            if (sequential) begin
                frame = seq_frame;
            end else if (flashing && phase[0]) begin
                frame = 16'h0000;
            end
        end
    end

endmodule

// File: rtl/arrow_decoder.sv
// Captures four phase frames from an arrow board, then scans all 64
// pattern/mode candidates against them and reports the decoded result.
module arrow_decoder
    import arrow_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [1:0]  phase,
    input  logic [15:0] lamps,
    input  logic        al,
    output logic        busy,
    output logic        valid,
    output logic [3:0]  pattern,
    output logic        flashing,
    output logic        sequential,
    output logic        ambiguous,
    output logic        lamp_test,
    output logic        blank,
    output logic        error
);

    state_e           state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic [3:0][15:0] f_q, f_d;
    logic [1:0]       exp_q, exp_d;
    logic             found_q, found_d;
    logic [3:0]       pat_q, pat_d;
    logic             fl_q, fl_d;
    logic             seq_q, seq_d;
    logic             amb_q, amb_d;
    result_t          res_q, res_d;
    logic             valid_q, valid_d;

    logic [15:0]      norm;
    logic [3:0][15:0] model_frame;
    logic             match;

    assign norm = lamps ^ {16{~al}};

    for (genvar p = 0; p < 4; p++) begin : g_model
        arrow_frame_model u_model (
            .pattern    (idx_q[5:2]),
            .phase      (2'(p)),
            .flashing   (idx_q[0]),
            .sequential (idx_q[1]),
            .frame      (model_frame[p])
        );
    end

    assign match = (model_frame == f_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        f_d     = f_q;
        exp_d   = exp_q;
        found_d = found_q;
        pat_d   = pat_q;
        fl_d    = fl_q;
        seq_d   = seq_q;
        amb_d   = amb_q;
        res_d   = res_q;
        valid_d = 1'b0;

        unique case (state_q)
            WAIT0: begin
                if (frame_valid && phase == 2'd0) begin
                    f_d[0]  = norm;
                    exp_d   = 2'd1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (frame_valid) begin
                    if (phase == exp_q) begin
                        f_d[phase] = norm;
                        exp_d      = exp_q + 2'd1;
                        if (phase == 2'd3) begin
                            idx_d   = 6'd0;
                            found_d = 1'b0;
                            amb_d   = 1'b0;
                            pat_d   = 4'd0;
                            fl_d    = 1'b0;
                            seq_d   = 1'b0;
                            state_d = SCAN;
                        end
                    end else if (phase == 2'd0) begin
                        f_d[0] = norm;
                        exp_d  = 2'd1;
                    end else begin
                        state_d = WAIT0;
                    end
                end
            end
            SCAN: begin
                if (match) begin
                    if (!found_q) begin
                        found_d = 1'b1;
                        pat_d   = idx_q[5:2];
                        fl_d    = idx_q[0];
                        seq_d   = idx_q[1];
                    end else if (idx_q[5:2] != pat_q) begin
                        amb_d = 1'b1;
                    end
                end
                if (idx_q == 6'd63) begin
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            REPORT: begin
                res_d   = '0;
                valid_d = 1'b1;
                if (f_q == {4{16'hFFFF}}) begin
                    res_d.lamp_test = 1'b1;
                end else if (f_q == {4{16'h0000}}) begin
                    res_d.blank = 1'b1;
                end else if (!found_q) begin
                    res_d.error = 1'b1;
                end else begin
                    res_d.pattern    = pat_q;
                    res_d.flashing   = fl_q;
                    res_d.sequential = seq_q;
                    res_d.ambiguous  = amb_q;
                end
                state_d = WAIT0;
            end
            default: state_d = WAIT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT0;
            idx_q   <= '0;
            f_q     <= '0;
            exp_q   <= '0;
            found_q <= 1'b0;
            pat_q   <= '0;
            fl_q    <= 1'b0;
            seq_q   <= 1'b0;
            amb_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            exp_q   <= exp_d;
            found_q <= found_d;
            pat_q   <= pat_d;
            fl_q    <= fl_d;
            seq_q   <= seq_d;
            amb_q   <= amb_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign busy       = (state_q == SCAN) || (state_q == REPORT);
    assign valid      = valid_q;
    assign pattern    = res_q.pattern;
    assign flashing   = res_q.flashing;
    assign sequential = res_q.sequential;
    assign ambiguous  = res_q.ambiguous;
    assign lamp_test  = res_q.lamp_test;
    assign blank      = res_q.blank;
    assign error      = res_q.error;

endmodule
